// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiply/divide controller.
package muldiv_seq_ctrl_pkg;
  localparam int WIDTH_DEF = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_seq_ctrl_iter.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide in one shared register.
module muldiv_iter_core
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  // mul: acc = {partial product, remaining multiplier}; div: acc = {remainder, quotient}
  logic [2*WIDTH:0] acc, acc_nxt;
  logic             op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   upper, rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo_sh;

  always_comb begin
    upper  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b_r} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    quo_sh = {acc[WIDTH-2:0], 1'b0};
    diff   = {1'b0, rem_sh} - {2'b00, b_r};
    if (op_r == OP_DIV) begin
      if (diff[WIDTH+1]) acc_nxt = {rem_sh, quo_sh};
      else               acc_nxt = {diff[WIDTH:0], quo_sh[WIDTH-1:1], 1'b1};
    end else begin
      acc_nxt = {1'b0, upper, acc[WIDTH-1:1]};
    end
  end

  // Result of the step in flight, so the controller can capture it on the last iteration edge
  assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];
  assign res_lo = acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      op_r <= OP_MUL;
      b_r  <= '0;
    end else if (load) begin
      acc  <= {{(WIDTH+1){1'b0}}, a};
      op_r <= op;
      b_r  <= b;
    end else if (run) begin
      acc  <= acc_nxt;
    end
  end
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle mul/div controller: FSM, iteration count, stall/done/div-by-zero and hi/lo registers.
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic               accept, dbz_case, last;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dbz_case  = 1'b0;
    last      = 1'b0;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          dbz_case  = (op == OP_DIV) && (opB == '0);
          stall     = 1'b1;
          state_nxt = dbz_case ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        last  = (count == CNT_W'(WIDTH - 1));
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .run    (busy),
    .op     (op),
    .a      (opA),
    .b      (opB),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count       <= '0;
        div_by_zero <= dbz_case;
        // Divide by zero skips the iterations and reports the conventional saturated result
        if (dbz_case) begin
          hi <= opA;
          lo <= '1;
        end
      end else if (busy) begin
        count <= count + CNT_W'(1);
        if (last) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: vector table plus ignored-start, reset-abort and back-to-back runs.
module tb_muldiv_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] opA = '0, opB = '0;
  logic        stall, busy, done, div_by_zero;
  logic [15:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .stall(stall), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [15:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issues one op at a negedge, waits for done, checks latency, stall profile and results.
  // poke>0 pulses a second start with other operands on that cycle; hold keeps start high.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] eh, input logic [15:0] el,
                        input logic edbz, input int poke, input bit hold, input string nm);
    int cyc;
    bit seen, prof_ok;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    #1;
    if (lat > 1) chk({nm, " stall@start"}, {31'b0, stall}, 32'd1);
    cyc = 0; seen = 0; prof_ok = 1;
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else if (!stall || !busy) prof_ok = 0;
      if (!seen || !hold) begin
        start = hold || (cyc == poke);
        if (cyc == poke) begin op = 1'b0; opA = 16'd7; opB = 16'd9; end
      end
    end
    chk({nm, " done_seen"}, {31'b0, seen}, 32'd1);
    chk({nm, " latency"}, cyc, lat);
    if (lat > 1) chk({nm, " stall/busy while running"}, {31'b0, prof_ok}, 32'd1);
    chk({nm, " stall@done"}, {31'b0, stall}, 32'd0);
    chk({nm, " hi"}, {16'b0, hi}, {16'b0, eh});
    chk({nm, " lo"}, {16'b0, lo}, {16'b0, el});
    chk({nm, " dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    if (!hold) begin
      @(negedge clk);
      chk({nm, " done one cycle"}, {31'b0, done}, 32'd0);
      chk({nm, " hold hi/lo"}, {hi, lo}, {eh, el});
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
    vecs[2]  = '{1'b1, 16'h000F, 16'h0002, 16'h0001, 16'h0007, 1'b0, 17};
    vecs[3]  = '{1'b1, 16'h0009, 16'h0000, 16'h0009, 16'hFFFF, 1'b1, 1};
    vecs[4]  = '{1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17};
    vecs[5]  = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
    vecs[6]  = '{1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 17};
    vecs[7]  = '{1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17};
    vecs[8]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17};
    vecs[9]  = '{1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[10] = '{1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 17};

    repeat (2) @(negedge clk);
    chk("reset busy/done/stall/dbz", {28'b0, busy, done, stall, div_by_zero}, 32'd0);
    chk("reset hi/lo", {hi, lo}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo,
             vecs[i].dbz, 0, 1'b0, $sformatf("vec%0d", i));

    // Second start during RUN must be ignored
    run_op(1'b0, 16'h0003, 16'h0005, 17, 16'h0000, 16'h000F, 1'b0, 4, 1'b0, "ignored_start");

    // Reset at RUN cycle 5 aborts and clears outputs at once
    @(negedge clk);
    start = 1'b1; op = 1'b0; opA = 16'h0003; opB = 16'h0005;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset-mid busy/stall/done", {29'b0, busy, stall, done}, 32'd0);
    chk("reset-mid hi/lo", {hi, lo}, 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op(1'b0, 16'h0002, 16'h0002, 17, 16'h0000, 16'h0004, 1'b0, 0, 1'b0, "after_reset");

    // start held high: each new op is accepted on the IDLE cycle after done
    run_op(1'b0, 16'h0006, 16'h0007, 17, 16'h0000, 16'h002A, 1'b0, 0, 1'b1, "b2b_0");
    run_op(1'b1, 16'h0064, 16'h000A, 17, 16'h0000, 16'h000A, 1'b0, 0, 1'b1, "b2b_1");
    run_op(1'b0, 16'h0100, 16'h0100, 17, 16'h0001, 16'h0000, 1'b0, 0, 1'b0, "b2b_2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
